spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- Synthesizable, clock-oversampled SPI flash target: the device end of the flash interface that the ics32 flash reader drives.
- It replaces the behavioural flash model in benches and FPGA loopback builds.
- Decodes SPI mode-0 command frames (READ 0x03, FAST_READ 0x0B, JEDEC ID 0x9F).
- Serves data bytes from a backing store through a simple synchronous read port.
- Drives MISO back to the initiator.

Parameters:
- ADDR_WIDTH, 24: backing-store address width (1..24). The upper bits of the 24-bit SPI address are ignored.
- JEDEC_ID, 24'hEF4018: manufacturer/type/capacity returned by 0x9F, MSB first.
- FAST_READ_DUMMY, 8: number of dummy SCK cycles after the address for 0x0B.

Ports:
- clk  input  1  system clock; must be at least 8x the SCK frequency
- reset_n  input  1  asynchronous active-low reset
- flash_sck  input  1  SPI clock from initiator, asynchronous to clk
- flash_csn  input  1  chip select, active low, asynchronous
- flash_mosi  input  1  serial data in, sampled on SCK rise
- flash_miso  output  1  serial data out, updated on SCK fall
- mem_addr  output  ADDR_WIDTH  byte address to backing store
- mem_read  output  1  one-cycle read strobe
- mem_rdata  input  8  read data, valid exactly 1 clk after mem_read
- busy  output  1  high while CSN is low and a frame is active
- cmd_unsupported  output  1  one-cycle pulse when an unknown opcode completes

Behaviour:
- Synchronisation:
  - sck, csn and mosi each pass through 2-FF synchronisers.
  - A third register on sck gives the rise/fall strobes; mosi is sampled from its synchronised copy on the sck rise strobe.
  - Total input latency is 3 clk; all timing below is in synchronised edges.
- Reset values: flash_miso=0, mem_addr=0, mem_read=0, busy=0, cmd_unsupported=0, state=IDLE, all counters and shift registers 0.
- Synchronised csn high forces state IDLE, busy=0 and flash_miso=0 in the same cycle, overriding everything, including mid-byte aborts. No pending read is honoured.
- State machine (bit counter counts SCK rises, MSB-first shift-in):
  - IDLE -> CMD on the csn fall; busy=1.
  - CMD: after 8 rises, the opcode is decoded:
    - 0x03 -> ADDR
    - 0x0B -> ADDR
    - 0x9F -> ID
    - otherwise -> IGNORE, with cmd_unsupported pulsed for 1 clk
  - ADDR: 24 rises shift the address.
    - On the 24th rise: mem_addr = addr[ADDR_WIDTH-1:0] and mem_read pulses.
    - 0x03 -> DATA; 0x0B -> DUMMY.
  - DUMMY: counts FAST_READ_DUMMY rises, then -> DATA. The fetch issued at the end of ADDR is held in the tx buffer.
  - DATA:
    - mem_rdata is captured into the tx buffer 1 clk after mem_read.
    - On each sck fall, flash_miso = tx_shift[7] and the register shifts left.
    - On the first fall of each byte, tx_shift loads from the buffer.
    - On the 1st rise of each byte, mem_addr increments and mem_read pulses, prefetching the next byte.
    - Bytes stream indefinitely until csn rises.
  - ID: shifts JEDEC_ID out MSB first on falls (24 bits), then drives 0 until csn rises.
  - IGNORE: drives 0 and consumes edges until csn rises.
- First data bit: MISO is driven on the fall that follows the last address or dummy rise. The fetch latency (1 clk) is well inside half an SCK period at the 8x ratio.
- mem_addr arithmetic: ADDR_WIDTH bits, increments modulo 2^ADDR_WIDTH (wraps from all-ones to 0).
- Simultaneous events: csn rise and sck edge in the same cycle -> csn wins and the edge is ignored. A new csn fall immediately after a rise starts a fresh CMD frame with counters cleared.
- reset_n asserted mid-frame: all outputs return to reset values immediately. After release, the block waits in IDLE until csn is seen high then low; no partial frame resumes.

Test Plan:
- Reset then READ: CSN low, send 0x03, 0x000010, clock 32 data bits; store[0x10..0x13]=A5,3C,FF,01 -> MISO bytes A5,3C,FF,01; mem_read pulses at addresses 0x10..0x14.
- FAST_READ: send 0x0B, 0x000200, 8 dummy cycles, 16 bits -> MISO returns store[0x200], store[0x201]; MISO=0 during the dummy cycles.
- JEDEC: send 0x9F, clock 32 bits -> EF,40,18,00; busy=1 throughout; no mem_read pulses.
- Wrap: ADDR_WIDTH=16, READ at 0xFFFF for 2 bytes -> mem_addr 0xFFFF then 0x0000. Address bits [23:16] set to 0xAB have no effect.
- Abort/unsupported: opcode 0x05 -> cmd_unsupported is a single 1-clk pulse and MISO stays 0. Raising CSN after 4 data bits of a READ -> busy=0 and MISO=0 within 3 clk; the next READ from 0x0 returns store[0] correctly.
- Async reset: assert reset_n low during DATA -> flash_miso, mem_read and busy are 0 before the next clk edge. After release, a full READ frame succeeds.

Source files
------------

// File: rtl/spi_flash_responder.sv
// Clock-oversampled SPI mode-0 flash target: decodes READ, FAST_READ and JEDEC ID
// frames and streams bytes from a synchronous backing store onto MISO.
`timescale 1ns/1ps

module spi_flash_responder #(
    parameter int          ADDR_WIDTH      = 24,
    parameter logic [23:0] JEDEC_ID        = 24'hEF4018,
    parameter int          FAST_READ_DUMMY = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flash_sck,
    input  logic                  flash_csn,
    input  logic                  flash_mosi,
    output logic                  flash_miso,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  cmd_unsupported
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DUMMY  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_ID     = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_csn_meta, r_csn_sync, r_csn_prev;
    logic r_mosi_meta, r_mosi_sync;

    logic [2:0]            r_state;
    logic [7:0]            r_bit_cnt;
    logic [2:0]            r_fall_cnt;
    logic [23:0]           r_shift;
    logic                  r_fast;
    logic [7:0]            r_tx_buf;
    logic [7:0]            r_tx_shift;
    logic                  r_fetch_pending;
    logic                  r_miso;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_read;
    logic                  r_busy;
    logic                  r_unsup;

    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_csn_fall;
    logic [23:0] w_shift_next;

    assign w_sck_rise   = r_sck_sync & ~r_sck_prev;
    assign w_sck_fall   = ~r_sck_sync & r_sck_prev;
    assign w_csn_fall   = r_csn_prev & ~r_csn_sync;
    assign w_shift_next = {r_shift[22:0], r_mosi_sync};

    // csn_prev resets low so a frame only starts after csn has been seen high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_prev  <= 1'b0;
            r_csn_meta  <= 1'b0;
            r_csn_sync  <= 1'b0;
            r_csn_prev  <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sck_meta  <= flash_sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_csn_meta  <= flash_csn;
            r_csn_sync  <= r_csn_meta;
            r_csn_prev  <= r_csn_sync;
            r_mosi_meta <= flash_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_bit_cnt       <= 8'd0;
            r_fall_cnt      <= 3'd0;
            r_shift         <= 24'd0;
            r_fast          <= 1'b0;
            r_tx_buf        <= 8'd0;
            r_tx_shift      <= 8'd0;
            r_fetch_pending <= 1'b0;
            r_miso          <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_read      <= 1'b0;
            r_busy          <= 1'b0;
            r_unsup         <= 1'b0;
        end else begin
            r_mem_read      <= 1'b0;
            r_unsup         <= 1'b0;
            r_fetch_pending <= r_mem_read;
            if (r_fetch_pending) begin
                r_tx_buf <= mem_rdata;
            end
            // Deselect overrides everything, including a pending fetch.
            if (r_csn_sync) begin
                r_state         <= S_IDLE;
                r_busy          <= 1'b0;
                r_miso          <= 1'b0;
                r_fetch_pending <= 1'b0;
                r_bit_cnt       <= 8'd0;
                r_fall_cnt      <= 3'd0;
                r_shift         <= 24'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_csn_fall) begin
                            r_state   <= S_CMD;
                            r_busy    <= 1'b1;
                            r_bit_cnt <= 8'd0;
                            r_shift   <= 24'd0;
                        end
                    end
                    S_CMD: begin
                        if (w_sck_rise) begin
                            r_shift <= w_shift_next;
                            if (r_bit_cnt == 8'd7) begin
                                r_bit_cnt <= 8'd0;
                                r_fast    <= (w_shift_next[7:0] == 8'h0B);
                                case (w_shift_next[7:0])
                                    8'h03, 8'h0B: r_state <= S_ADDR;
                                    8'h9F: begin
                                        r_state <= S_ID;
                                        r_shift <= JEDEC_ID;
                                    end
                                    default: begin
                                        r_state <= S_IGNORE;
                                        r_unsup <= 1'b1;
                                    end
                                endcase
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 8'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_sck_rise) begin
                            r_shift <= w_shift_next;
                            if (r_bit_cnt == 8'd23) begin
                                r_bit_cnt  <= 8'd0;
                                r_fall_cnt <= 3'd0;
                                r_mem_addr <= w_shift_next[ADDR_WIDTH-1:0];
                                r_mem_read <= 1'b1;
                                r_state    <= (r_fast && FAST_READ_DUMMY != 0) ? S_DUMMY : S_DATA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 8'd1;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (w_sck_rise) begin
                            if (r_bit_cnt == 8'(FAST_READ_DUMMY - 1)) begin
                                r_bit_cnt <= 8'd0;
                                r_state   <= S_DATA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 8'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_sck_fall) begin
                            if (r_fall_cnt == 3'd0) begin
                                r_miso     <= r_tx_buf[7];
                                r_tx_shift <= {r_tx_buf[6:0], 1'b0};
                            end else begin
                                r_miso     <= r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            end
                            r_fall_cnt <= r_fall_cnt + 3'd1;
                        end
                        // Prefetch the next byte on the first rise of the current one.
                        if (w_sck_rise) begin
                            if (r_bit_cnt == 8'd0) begin
                                r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                                r_mem_read <= 1'b1;
                            end
                            r_bit_cnt <= (r_bit_cnt == 8'd7) ? 8'd0 : r_bit_cnt + 8'd1;
                        end
                    end
                    S_ID: begin
                        if (w_sck_fall) begin
                            r_miso  <= r_shift[23];
                            r_shift <= {r_shift[22:0], 1'b0};
                        end
                    end
                    S_IGNORE: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign flash_miso      = r_miso;
    assign mem_addr        = r_mem_addr;
    assign mem_read        = r_mem_read;
    assign busy            = r_busy;
    assign cmd_unsupported = r_unsup;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: an SPI initiator driven at 1/16 of clk
// against a byte-array backing store and a sequential-read reference model.
`timescale 1ns/1ps

module tb_spi_flash_responder;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flash_sck = 1'b0;
    logic          flash_csn = 1'b1;
    logic          flash_mosi = 1'b0;
    logic          flash_miso;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic [7:0]    mem_rdata = 8'd0;
    logic          busy;
    logic          cmd_unsupported;

    logic [7:0]    store [0:65535];
    logic [AW-1:0] readLog [$];
    int            unsupHighCycles = 0;
    int            checkCount = 0;
    int            failCount = 0;

    spi_flash_responder #(
        .ADDR_WIDTH      (AW),
        .JEDEC_ID        (24'hEF4018),
        .FAST_READ_DUMMY (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flash_sck       (flash_sck),
        .flash_csn       (flash_csn),
        .flash_mosi      (flash_mosi),
        .flash_miso      (flash_miso),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .cmd_unsupported (cmd_unsupported)
    );

    always #5 clk = ~clk;

    // Backing store answers one clk after the strobe; every strobe address is logged.
    always @(posedge clk) begin
        mem_rdata <= store[mem_addr];
        if (mem_read) readLog.push_back(mem_addr);
        if (cmd_unsupported) unsupHighCycles++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One SCK period: MISO is sampled just before the rise, as the initiator would.
    task automatic spiClock(input logic mosiBit, output logic misoBit);
        flash_mosi = mosiBit;
        tick(8);
        misoBit = flash_miso;
        flash_sck = 1'b1;
        tick(8);
        flash_sck = 1'b0;
    endtask

    task automatic sendBits(input logic [31:0] value, input int n);
        logic unused;
        for (int i = n - 1; i >= 0; i--) spiClock(value[i], unused);
    endtask

    task automatic recvBits(input int n, output logic [63:0] data);
        logic b;
        data = 64'd0;
        for (int i = 0; i < n; i++) begin
            spiClock(1'($urandom_range(0, 1)), b);
            data = {data[62:0], b};
        end
    endtask

    task automatic beginFrame();
        readLog.delete();
        unsupHighCycles = 0;
        flash_csn = 1'b0;
        tick(6);
    endtask

    task automatic endFrame();
        flash_csn = 1'b1;
        tick(8);
    endtask

    function automatic logic [63:0] expectedStream(input logic [23:0] addr, input int nBytes);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < nBytes; i++) r = {r[55:0], store[(int'(addr[15:0]) + i) % 65536]};
        return r;
    endfunction

    task automatic checkReadLog(input string tag, input logic [23:0] addr, input int nBytes);
        checkOutput({tag, "_reads"}, 64'(readLog.size()), 64'(nBytes + 1));
        for (int i = 0; i <= nBytes && i < readLog.size(); i++)
            checkOutput({tag, "_addr"}, 64'(readLog[i]), 64'((int'(addr[15:0]) + i) % 65536));
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] op, input logic [23:0] addr,
                                 input int nBytes, output logic [63:0] data);
        logic b;
        beginFrame();
        sendBits({24'd0, op}, 8);
        sendBits({8'd0, addr}, 24);
        if (op == 8'h0B) begin
            for (int i = 0; i < 8; i++) begin
                spiClock(1'($urandom_range(0, 1)), b);
                checkOutput({tag, "_dummy_miso"}, 64'(b), 64'd0);
            end
        end
        recvBits(nBytes * 8, data);
        endFrame();
    endtask

    initial begin
        logic [63:0] data;
        logic [7:0]  op;
        logic [23:0] addr;
        int          nBytes;
        int          busyLow;
        logic        b;

        for (int i = 0; i < 65536; i++) store[i] = 8'($urandom);
        store[16'h0010] = 8'hA5;
        store[16'h0011] = 8'h3C;
        store[16'h0012] = 8'hFF;
        store[16'h0013] = 8'h01;

        tick(3);
        checkOutput("reset_miso", 64'(flash_miso), 64'd0);
        checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset_mem_read", 64'(mem_read), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_unsup", 64'(cmd_unsupported), 64'd0);
        reset_n = 1'b1;
        tick(4);

        applyStimulus("read", 8'h03, 24'h000010, 4, data);
        checkOutput("read_data", data, 64'hA53CFF01);
        checkReadLog("read", 24'h000010, 4);

        applyStimulus("fast", 8'h0B, 24'h000200, 2, data);
        checkOutput("fast_data", data, expectedStream(24'h000200, 2));
        checkReadLog("fast", 24'h000200, 2);

        beginFrame();
        sendBits(32'h9F, 8);
        data = 64'd0;
        busyLow = 0;
        for (int i = 0; i < 32; i++) begin
            spiClock(1'($urandom_range(0, 1)), b);
            data = {data[62:0], b};
            if (busy !== 1'b1) busyLow++;
        end
        checkOutput("jedec_data", data, 64'hEF401800);
        checkOutput("jedec_busy_low", 64'(busyLow), 64'd0);
        checkOutput("jedec_reads", 64'(readLog.size()), 64'd0);
        endFrame();

        applyStimulus("wrap", 8'h03, 24'hABFFFF, 2, data);
        checkOutput("wrap_data", data, {48'd0, store[16'hFFFF], store[16'h0000]});
        checkReadLog("wrap", 24'h00FFFF, 2);

        beginFrame();
        sendBits(32'h05, 8);
        recvBits(24, data);
        checkOutput("unsup_miso", data, 64'd0);
        checkOutput("unsup_pulse_cycles", 64'(unsupHighCycles), 64'd1);
        checkOutput("unsup_reads", 64'(readLog.size()), 64'd0);
        endFrame();

        beginFrame();
        sendBits(32'h03, 8);
        sendBits(32'h000012, 24);
        recvBits(4, data);
        checkOutput("abort_partial", data, 64'hF);
        flash_csn = 1'b1;
        tick(3);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_miso", 64'(flash_miso), 64'd0);
        tick(5);
        applyStimulus("after_abort", 8'h03, 24'h000000, 1, data);
        checkOutput("after_abort_data", data, {56'd0, store[0]});

        for (int k = 0; k < 5; k++) begin
            op     = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h0B;
            addr   = 24'($urandom);
            nBytes = $urandom_range(1, 6);
            applyStimulus("rand", op, addr, nBytes, data);
            checkOutput("rand_data", data, expectedStream(addr, nBytes));
            checkReadLog("rand", addr, nBytes);
        end

        beginFrame();
        sendBits(32'h03, 8);
        sendBits(32'h000010, 24);
        recvBits(12, data);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_miso", 64'(flash_miso), 64'd0);
        checkOutput("async_mem_read", 64'(mem_read), 64'd0);
        checkOutput("async_busy", 64'(busy), 64'd0);
        flash_csn = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(6);
        applyStimulus("post_reset", 8'h03, 24'h000011, 3, data);
        checkOutput("post_reset_data", data, 64'h3CFF01);
        checkReadLog("post_reset", 24'h000011, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
